// File: rtl/decomp_pkg.sv
// Shared types and defaults for the compressed instruction fetch queue.
// Entries pair a fetched word with the address it was fetched from.
package decomp_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] PCADD_DEF = 32'h4;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo_mem.sv
// Entry storage for the fetch queue: one write port, asynchronous head read.
// Contents need no reset; the top only exposes entries below count.
module fetch_fifo_mem
    import decomp_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t rdata
);

    fetch_entry_t mem [DEPTH];

    // Write the returned word into the slot at the write pointer.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/compressed_fetch_queue.sv
// Prefetch queue ahead of the decompressor: issues sequential reads,
// buffers returned words and restarts cleanly on a redirect.
module compressed_fetch_queue
    import decomp_pkg::*;
#(
    parameter  int              WIDTH    = XLEN,
    parameter  logic [WIDTH-1:0] PCADD    = PCADD_DEF,
    parameter  int              DEPTH    = 4,
    parameter  logic [WIDTH-1:0] RESET_PC = RESET_PC_DEF,
    localparam int              AW       = $clog2(DEPTH),
    localparam int              CW       = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirectPC,
    input  logic             consume,
    output logic             memReq,
    output logic [WIDTH-1:0] memAddr,
    input  logic [WIDTH-1:0] memRdata,
    output logic             fetchValid,
    output logic [WIDTH-1:0] fetchInstr,
    output logic [WIDTH-1:0] fetchPC,
    output logic [CW-1:0]    count
);

    fetch_state_t     state;
    fetch_state_t     state_n;
    logic             pending;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] next_pc;
    logic [WIDTH-1:0] req_pc;
    logic [CW:0]      inflight;
    logic             issue;
    logic             push;
    logic             pop;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // Entries held plus the one read in flight must fit in the FIFO.
    assign inflight = {1'b0, count_q} + (CW+1)'(pending);
    assign issue    = reset & ~redirect & (inflight < (CW+1)'(DEPTH));
    assign push     = pending & (state == RUN) & ~redirect;
    assign pop      = consume & (count_q != '0) & ~redirect;

    assign wr_entry = '{instr: memRdata, pc: req_pc};

    fetch_fifo_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(wr_entry),
        .raddr(rd_ptr),
        .rdata(head)
    );

    // Fetch state moves to RUN on the first issue, back to IDLE on redirect.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (issue) state_n = RUN;
            RUN:  if (redirect) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Pointers, occupancy, request tracking and fetch address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            next_pc <= RESET_PC;
            req_pc  <= '0;
            pending <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (redirect) begin
            next_pc <= redirectPC;
            pending <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            pending <= issue;
            if (issue) begin
                next_pc <= next_pc + PCADD;
                req_pc  <= next_pc;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // The credit check must make a push into a full queue impossible.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            assert (count_q != CW'(DEPTH));
        end
    end

    assign memReq     = issue;
    assign memAddr    = next_pc;
    assign count      = count_q;
    assign fetchValid = (count_q != '0);
    assign fetchInstr = fetchValid ? head.instr : '0;
    assign fetchPC    = fetchValid ? head.pc : '0;

endmodule

// File: tb/tb_compressed_fetch_queue.sv
// Scoreboard bench for compressed_fetch_queue: directed phases push the
// expected PC stream, a negedge monitor checks every popped head entry.
module tb_compressed_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirectPC;
    logic        consume;
    logic        memReq;
    logic [31:0] memAddr;
    logic [31:0] memRdata;
    logic        fetchValid;
    logic [31:0] fetchInstr;
    logic [31:0] fetchPC;
    logic [2:0]  count;

    int          checks = 0;
    int          failures = 0;
    int          req_total = 0;
    bit          streaming = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    compressed_fetch_queue dut (
        .clk       (clk),
        .reset     (reset),
        .redirect  (redirect),
        .redirectPC(redirectPC),
        .consume   (consume),
        .memReq    (memReq),
        .memAddr   (memAddr),
        .memRdata  (memRdata),
        .fetchValid(fetchValid),
        .fetchInstr(fetchInstr),
        .fetchPC   (fetchPC),
        .count     (count)
    );

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // Instruction memory model with one cycle of read latency.
    always @(posedge clk) begin
        memRdata <= memReq ? mdata(memAddr) : 32'hDEAD_BEEF;
    end

    always @(posedge clk) begin
        if (memReq) req_total <= req_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next edge whenever the head is
    // valid, consume is high and no redirect is pending.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (reset === 1'b1 && fetchValid === 1'b1 &&
            consume === 1'b1 && redirect === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got pc %h expected none",
                         fetchPC);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", fetchPC, e);
                chk("pop_instr", fetchInstr, mdata(e));
            end
        end
        if (streaming) begin
            chk("stream_count_le2", {31'b0, count <= 3'd2}, 32'd1);
        end
    end

    task automatic drain(input int budget, output int cycles);
        cycles = 0;
        while (exp_q.size() != 0 && cycles < budget) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d left expected 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int s;
        int n;
        reset      = 1'b0;
        redirect   = 1'b0;
        consume    = 1'b0;
        redirectPC = 32'h0;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        chk("rst_memReq", {31'b0, memReq}, 32'd0);
        chk("rst_valid", {31'b0, fetchValid}, 32'd0);
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_fetchPC", fetchPC, 32'h0);
        chk("rst_fetchInstr", fetchInstr, 32'h0);

        // Release, then fill with consume low.
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("rel_memReq", {31'b0, memReq}, 32'd1);
        chk("rel_memAddr", memAddr, 32'h0);
        s = req_total;
        @(negedge clk);
        chk("rel2_memReq", {31'b0, memReq}, 32'd1);
        chk("rel2_memAddr", memAddr, 32'h4);
        repeat (8) @(negedge clk);
        chk("fill_reqs", req_total - s, 32'd4);
        chk("fill_count", {29'b0, count}, 32'd4);
        chk("fill_memReq", {31'b0, memReq}, 32'd0);
        chk("fill_headpc", fetchPC, 32'h0);
        chk("fill_headinstr", fetchInstr, mdata(32'h0));

        // Redirect together with consume on a full queue.
        step();
        redirect   = 1'b1;
        redirectPC = 32'h200;
        consume    = 1'b1;
        @(negedge clk);
        chk("rc_memReq", {31'b0, memReq}, 32'd0);
        chk("rc_count_pre", {29'b0, count}, 32'd4);
        step();
        redirect = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'h200 + 32'(4 * i));
        @(negedge clk);
        chk("rc_count_post", {29'b0, count}, 32'd0);
        chk("rc_valid_post", {31'b0, fetchValid}, 32'd0);
        chk("rc_memReq_post", {31'b0, memReq}, 32'd1);
        chk("rc_memAddr_post", memAddr, 32'h200);
        drain(60, n);
        step();
        consume = 1'b0;

        // Redirect while a read is in flight.
        step();
        redirect   = 1'b1;
        redirectPC = 32'h80;
        step();
        redirect = 1'b0;
        @(negedge clk);
        chk("pd_memReq", {31'b0, memReq}, 32'd1);
        chk("pd_memAddr", memAddr, 32'h80);
        step();
        redirect   = 1'b1;
        redirectPC = 32'h100;
        consume    = 1'b1;
        @(negedge clk);
        chk("pd_redir_memReq", {31'b0, memReq}, 32'd0);
        step();
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(4 * i));
        @(negedge clk);
        chk("pd_memAddr_new", memAddr, 32'h100);
        chk("pd_valid_0", {31'b0, fetchValid}, 32'd0);
        @(negedge clk);
        chk("pd_valid_1", {31'b0, fetchValid}, 32'd0);
        @(negedge clk);
        chk("pd_valid_2", {31'b0, fetchValid}, 32'd1);
        chk("pd_first_pc", fetchPC, 32'h100);
        drain(40, n);
        step();
        consume = 1'b0;

        // Address wrap and pointer wrap over three queue depths.
        step();
        redirect   = 1'b1;
        redirectPC = 32'hFFFF_FFF8;
        consume    = 1'b1;
        step();
        redirect = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_q.push_back(32'hFFFF_FFF8 + 32'(4 * i));
        end
        drain(60, n);
        step();
        consume = 1'b0;

        // Reset mid-stream, then stream with consume held high.
        step();
        reset   = 1'b0;
        consume = 1'b1;
        @(negedge clk);
        chk("mid_rst_count", {29'b0, count}, 32'd0);
        chk("mid_rst_valid", {31'b0, fetchValid}, 32'd0);
        chk("mid_rst_memAddr", memAddr, 32'h0);
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(4 * i));
        step();
        step();
        reset     = 1'b1;
        streaming = 1'b1;
        drain(100, n);
        chk("stream_cycles", n, 32'd18);
        step();
        consume   = 1'b0;
        streaming = 1'b0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
